// File: rtl/ebike_pkg.sv
// Shared types and widths for the e-bike pedal sensor path.
package ebike_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PEDAL = 1'b1
  } pedal_state_t;

  localparam int ACC_W     = 16;
  localparam int AVG_SHIFT = 4;
  localparam int TORQUE_W  = 12;
  localparam int CAD_W     = 5;

  // Saturating increment of a cadence edge count.
  function automatic logic [CAD_W-1:0] sat_inc(input logic [CAD_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/pedal_debounce.sv
// Cadence input conditioning: 2-flop sync, stability-count debounce, rise pulse.
module pedal_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, flip;

  assign differ = s2_q ^ level_q;
  assign flip   = differ && (cnt_q == CW'(DEB_CYCLES - 1));

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (flip) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: windowed cadence count, pedaling FSM, torque EMA.
module pedal_sensor_cond
  import ebike_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int CAD_WIN      = 2**22,
  parameter int START_THRESH = 2,
  parameter int STOP_THRESH  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cadence_raw,
  input  logic [TORQUE_W-1:0] torque_raw,
  input  logic                torque_vld,
  output logic [CAD_W-1:0]    cadence,
  output logic                cadence_upd,
  output logic                not_pedaling,
  output logic [TORQUE_W-1:0] avg_torque
);

  localparam int WIN_W = (CAD_WIN > 1) ? $clog2(CAD_WIN) : 1;

  logic rise;
  logic deb_level_unused;

  pedal_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (cadence_raw),
    .level_o (deb_level_unused),
    .rise_o  (rise)
  );

  logic [WIN_W-1:0]    win_q, win_d;
  logic [CAD_W-1:0]    ecnt_q, ecnt_d, ecnt_n;
  logic [CAD_W-1:0]    cad_q, cad_d;
  pedal_state_t        state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TORQUE_W-1:0] smpl_q, smpl_d;
  logic [TORQUE_W-1:0] avg_q;
  logic                upd_q, np_q;
  logic                wrap, stop;

  assign wrap = (win_q == WIN_W'(CAD_WIN - 1));

  always_comb begin
    win_d   = wrap ? '0 : win_q + 1'b1;
    // A rise on the wrap cycle still belongs to the closing window.
    ecnt_n  = sat_inc(ecnt_q, rise);
    ecnt_d  = wrap ? '0 : ecnt_n;
    cad_d   = wrap ? ecnt_n : cad_q;
    state_d = state_q;
    if (wrap) begin
      unique case (state_q)
        IDLE:    if (ecnt_n >= CAD_W'(START_THRESH)) state_d = PEDAL;
        PEDAL:   if (ecnt_n <  CAD_W'(STOP_THRESH))  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    stop   = (state_q == PEDAL) && (state_d == IDLE);
    acc_d  = acc_q;
    if (stop)
      acc_d = '0;
    else if (rise)
      acc_d = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(smpl_q);
    smpl_d = torque_vld ? torque_raw : smpl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      ecnt_q  <= '0;
      cad_q   <= '0;
      state_q <= IDLE;
      acc_q   <= '0;
      smpl_q  <= '0;
      avg_q   <= '0;
      upd_q   <= 1'b0;
      np_q    <= 1'b1;
    end else begin
      win_q   <= win_d;
      ecnt_q  <= ecnt_d;
      cad_q   <= cad_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      smpl_q  <= smpl_d;
      avg_q   <= acc_q[ACC_W-1:AVG_SHIFT];
      upd_q   <= wrap;
      np_q    <= (state_d == IDLE);
    end
  end

  assign cadence      = cad_q;
  assign cadence_upd  = upd_q;
  assign not_pedaling = np_q;
  assign avg_torque   = avg_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Bench for pedal_sensor_cond: per-cycle reference model, window table, corner sequences.
module tb_pedal_sensor_cond;

  localparam int DEB   = 4;
  localparam int WIN   = 1000;
  localparam int START = 2;
  localparam int STOP  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cadence_raw;
  logic [11:0] torque_raw;
  logic        torque_vld;
  logic [4:0]  cadence;
  logic        cadence_upd;
  logic        not_pedaling;
  logic [11:0] avg_torque;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pedal_sensor_cond #(
    .DEB_CYCLES(DEB), .CAD_WIN(WIN), .START_THRESH(START), .STOP_THRESH(STOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cadence_raw  (cadence_raw),
    .torque_raw   (torque_raw),
    .torque_vld   (torque_vld),
    .cadence      (cadence),
    .cadence_upd  (cadence_upd),
    .not_pedaling (not_pedaling),
    .avg_torque   (avg_torque)
  );

  // Reference model: debounce as "last DEB synchronized samples all disagree
  // with the level", cadence as a plain per-window count clamped at 31.
  typedef struct packed {
    bit [5:0] hist;
    bit       level;
    bit       rise;
    int       t;
    int       cnt;
    bit       pedal;
    int       acc;
    int       smpl;
    int       cad;
    bit       upd;
    int       avg;
  } mst_t;

  mst_t m;

  function automatic mst_t m_step(mst_t s, bit raw, int tq, bit tv);
    mst_t n = s;
    bit   all_diff = 1'b1;
    int   c;
    for (int i = 1; i <= DEB; i++) if (s.hist[i] == s.level) all_diff = 1'b0;
    n.rise = all_diff && !s.level;
    if (all_diff) n.level = !s.level;
    n.hist = {s.hist[4:0], raw};
    c = s.cnt + (s.rise ? 1 : 0);
    n.upd = (s.t == WIN - 1);
    if (s.t == WIN - 1) begin
      n.t   = 0;
      n.cnt = 0;
      n.cad = (c > 31) ? 31 : c;
      if (!s.pedal && n.cad >= START) n.pedal = 1'b1;
      else if (s.pedal && n.cad < STOP) n.pedal = 1'b0;
    end else begin
      n.t   = s.t + 1;
      n.cnt = c;
    end
    n.avg = s.acc / 16;
    if (s.pedal && !n.pedal) n.acc = 0;
    else if (s.rise) n.acc = s.acc - s.acc / 16 + s.smpl;
    if (tv) n.smpl = tq;
    return n;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m <= '0;
    else     m <= m_step(m, cadence_raw, int'(torque_raw), torque_vld);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Compare against the model on the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en)
      check("model", {13'd0, cadence, cadence_upd, not_pedaling, avg_torque},
            {13'd0, m.cad[4:0], m.upd, ~m.pedal, m.avg[11:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 3000 && m.t != target; i++) tick();
    if (m.t != target) check("window position timeout", m.t, target);
  endtask

  task automatic pulse(input int w, input int g);
    cadence_raw = 1'b1;
    repeat (w) tick();
    cadence_raw = 1'b0;
    repeat (g) tick();
  endtask

  typedef struct {
    int          pulses;
    logic [11:0] tq;
    int          exp_cad;
    bit          exp_np;
  } win_vec_t;

  win_vec_t tbl[5];

  task automatic run_window(input win_vec_t v);
    wait_t(2);
    torque_raw = v.tq;
    torque_vld = 1'b1;
    tick();
    torque_vld = 1'b0;
    repeat (v.pulses) pulse(10, 10);
    wait_t(0);
    check("table cadence", cadence, v.exp_cad);
    check("table not_pedaling", not_pedaling, v.exp_np);
    check("table cadence_upd", cadence_upd, 1);
  endtask

  int run;

  initial begin
    tbl[0] = '{5,  12'h800, 5,  1'b0};
    tbl[1] = '{8,  12'h800, 8,  1'b0};
    tbl[2] = '{30, 12'h800, 30, 1'b0};
    tbl[3] = '{30, 12'h800, 30, 1'b0};
    tbl[4] = '{30, 12'h800, 30, 1'b0};

    rst = 1'b1; cadence_raw = 1'b0; torque_raw = '0; torque_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cadence", cadence, 0);
    check("reset cadence_upd", cadence_upd, 0);
    check("reset not_pedaling", not_pedaling, 1);
    check("reset avg_torque", avg_torque, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Glitch rejection, then one clean pulse with known rise latency
    wait_t(5);
    torque_raw = 12'h800; torque_vld = 1'b1;
    tick();
    torque_vld = 1'b0;
    cadence_raw = 1'b1; repeat (3) tick();
    cadence_raw = 1'b0; repeat (10) tick();
    cadence_raw = 1'b1;
    repeat (7) tick();
    check("avg before first rise", avg_torque, 0);
    tick();
    check("avg after first rise", avg_torque, 12'h080);
    repeat (2) tick();
    cadence_raw = 1'b0;
    wait_t(0);
    check("glitch window cadence", cadence, 1);
    check("glitch window not_pedaling", not_pedaling, 1);
    check("glitch window cadence_upd", cadence_upd, 1);
    tick();
    check("cadence_upd one cycle", cadence_upd, 0);

    foreach (tbl[i]) run_window(tbl[i]);
    check("avg converged", (avg_torque >= 12'h7F8 && avg_torque <= 12'h800), 1);

    // 40 rises, the last on the wrap cycle
    wait_t(2);
    repeat (39) pulse(8, 8);
    wait_t(993);
    cadence_raw = 1'b1;
    wait_t(0);
    check("saturated cadence", cadence, 31);
    check("saturated not_pedaling", not_pedaling, 0);
    wait_t(2);
    cadence_raw = 1'b0;

    // One mid-window rise plus one landing on the cycle after the wrap
    wait_t(100);
    pulse(10, 10);
    wait_t(994);
    cadence_raw = 1'b1;
    wait_t(0);
    check("post-wrap rise excluded", cadence, 1);
    check("hold pedal at stop thresh", not_pedaling, 0);
    wait_t(5);
    cadence_raw = 1'b0;
    wait_t(993);
    cadence_raw = 1'b1;
    wait_t(0);
    check("post-wrap + wrap rise counted", cadence, 2);
    wait_t(5);
    cadence_raw = 1'b0;

    // Empty window stops pedaling and clears the average
    wait_t(0);
    check("stop cadence", cadence, 0);
    check("stop not_pedaling", not_pedaling, 1);
    tick();
    check("stop avg cleared", avg_torque, 0);
    wait_t(100);
    pulse(10, 10);
    wait_t(0);
    check("idle single rise cadence", cadence, 1);
    check("idle single rise stays idle", not_pedaling, 1);

    // Random traffic against the model
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        cadence_raw = ~cadence_raw;
        run = $urandom_range(12, 1);
      end
      run--;
      torque_raw = 12'($urandom);
      torque_vld = ($urandom_range(7, 0) == 0);
      tick();
    end
    torque_vld = 1'b0;
    cadence_raw = 1'b0;

    // Asynchronous reset mid-window with a loaded accumulator
    torque_raw = 12'h5A5; torque_vld = 1'b1;
    tick();
    torque_vld = 1'b0;
    pulse(10, 10);
    pulse(10, 10);
    rst = 1'b1;
    #1;
    check("async rst cadence", cadence, 0);
    check("async rst cadence_upd", cadence_upd, 0);
    check("async rst not_pedaling", not_pedaling, 1);
    check("async rst avg_torque", avg_torque, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("post-reset cadence", cadence, 0);
    check("post-reset not_pedaling", not_pedaling, 1);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/pedal_sensor_cond.md
Name: pedal_sensor_cond

Overview:
- Conditions raw pedal sensors into the operands consumed by the assist-current computation stage: `cadence` (5b), `not_pedaling`, `avg_torque` (12b).
- Synchronizes and debounces the cadence pulse and counts edges per fixed window.
- Tracks pedaling state with hysteresis.
- Maintains an exponential average of torque, sampled once per pedal edge.
- Sits between the sensor/ADC interface and the desired-drive stage.

Parameters:
- DEB_CYCLES, 16, consecutive stable synchronized samples required to change the debounced level.
- CAD_WIN, 2**22, window length in clk cycles for cadence counting.
- START_THRESH, 2, window count at or above which IDLE moves to PEDAL.
- STOP_THRESH, 1, window count below which PEDAL moves to IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cadence_raw  in  1  asynchronous pedal-magnet pulse
- torque_raw  in  12  unsigned torque ADC sample
- torque_vld  in  1  one-cycle strobe qualifying torque_raw
- cadence  out  5  debounced edges counted in the last completed window, saturated at 31
- cadence_upd  out  1  one-cycle pulse when `cadence` is updated
- not_pedaling  out  1  high while the FSM is in IDLE
- avg_torque  out  12  exponentially averaged torque

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: cadence=0, cadence_upd=0, not_pedaling=1, avg_torque=0, FSM=IDLE. All internal counters, the accumulator and torque_smpl reset to 0. Sync and debounce flops reset to 0.
- Reset mid-operation: everything returns to the reset values immediately, regardless of window position.
- Sync: cadence_raw passes through a 2-flop synchronizer.
- Debounce:
  - A stability counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level toggles on the next edge and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
- Edge: `rise` is a one-cycle pulse on a debounced 0->1 transition.
  - Latency from a clean cadence_raw rise to `rise`: 2 + DEB_CYCLES cycles.
- Window counter:
  - Counts 0..CAD_WIN-1 and wraps.
  - Edge counter `ecnt` (5b) increments on `rise`, saturating at 31.
  - On the wrap cycle: cadence <= ecnt (including a `rise` in that same cycle), cadence_upd=1 for that cycle, and ecnt restarts at 0.
  - A `rise` in the cycle after the wrap counts toward the new window.
- FSM, evaluated only on the wrap cycle, using the new window count n:
  - IDLE -> PEDAL when n >= START_THRESH.
  - PEDAL -> IDLE when n < STOP_THRESH.
  - Otherwise hold.
  - not_pedaling changes together with the registered cadence (same edge).
- Torque sample: torque_smpl <= torque_raw on torque_vld; otherwise it holds.
- Accumulator (16b unsigned):
  - On `rise`: acc <= acc - (acc>>4) + torque_smpl.
  - Uses the registered torque_smpl, so a torque_vld in the same cycle takes effect only on the next rise.
  - No overflow is possible: steady-state max is 16*4095 = 65520.
  - avg_torque = acc[15:4], registered.
  - On the PEDAL->IDLE transition, acc clears to 0. If `rise` coincides with that transition, the clear wins.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package `ebike_pkg`:
  - enum `pedal_state_t` {IDLE, PEDAL}
  - localparam ACC_W=16
  - localparam AVG_SHIFT=4
  - localparam TORQUE_W=12
- Sub-module `pedal_debounce`:
  - Contains the synchronizer, stability counter and rise-pulse generation.
  - Parameter DEB_CYCLES; outputs `level` and `rise`.
- The top level holds the window counter, FSM and accumulator.

Test Plan (DEB_CYCLES=4, CAD_WIN=1000, START_THRESH=2, STOP_THRESH=1):
- Reset: assert rst mid-window with acc nonzero -> all outputs return to reset values within the same cycle (async). After release, not_pedaling=1 and cadence=0.
- Glitch rejection: cadence_raw high for 3 cycles, then 1 clean 10-cycle pulse -> exactly one rise, seen 6 cycles after the clean edge. At the wrap, cadence=1, not_pedaling stays 1.
- Start pedaling: 5 clean pulses in window 1 -> at wrap, cadence=5, cadence_upd pulses once, not_pedaling falls to 0 on the same edge.
- Torque average: torque_raw=0x800 with vld before each rise, pedaling steadily -> avg_torque follows 0x080, 0x0F8, ... and converges to 0x7FF/0x800 within ~100 rises, never exceeding 0x800.
- Saturation and boundary: 40 rises in one window, one of them on the wrap cycle -> cadence=31. A rise on the cycle after the wrap -> next window's count starts at 1.
- Stop: a window with 0 rises after pedaling -> not_pedaling=1, avg_torque=0 on the next cycle. A following window with 1 rise keeps IDLE (1 < START_THRESH).
